result_scoreboard: RTL and testbench

- Downstream checker stage for the registered-generate test harness.
- Samples the stimulus bit driven into the generate-loop instance, and the result bit that instance produces.
- Delays the stimulus by a fixed LATENCY and compares it against the observed result for NUM_CHECKS consecutive cycles.
- Reports an error count, the first mismatch index and a pass/fail verdict, so the top-level test can replace hand-coded per-cycle checks followed by $stop.

---
 rtl/tb_check_pkg.sv | 20 ++
 rtl/bit_delay_line.sv | 34 +++
 rtl/result_scoreboard.sv | 103 ++++++++++
 tb/tb_result_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tb_check_pkg.sv
// Shared types and helpers for the result scoreboard and its delay line.
package tb_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_LATENCY = 15;

    // Increment v, sticking at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bit_delay_line.sv
// DEPTH-stage shift register for a single bit; DEPTH=0 is a plain wire.
module bit_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_sr
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/result_scoreboard.sv
// Compares a LATENCY-delayed copy of stim against obs for NUM_CHECKS cycles
// and reports mismatch count, first mismatch index and a pass verdict.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// FILL  | waiting for the delay line to hold sample 0
// CHECK | one comparison per edge, idx = 0..NUM_CHECKS-1
// DONE  | verdict valid, waiting for start
module result_scoreboard
    import tb_check_pkg::*;
#(
    parameter int LATENCY    = 1,
    parameter int NUM_CHECKS = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stim,
    input  logic             obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int FILL_W = $clog2(MAX_LATENCY + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_CHECKS - 1);
    localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'((LATENCY > 1) ? LATENCY - 1 : 1);

    state_t            state;
    logic [CNT_W-1:0]  idx;
    logic [FILL_W-1:0] fill_cnt;
    logic              exp_bit;
    logic              mismatch;
    logic              launch;

    bit_delay_line #(.DEPTH(LATENCY)) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (stim),
        .q   (exp_bit)
    );

    assign mismatch = obs ^ exp_bit;
    assign launch   = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            fill_cnt        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        // With zero latency, sample 0 is compared on the start edge itself.
                        first_err_idx   <= '0;
                        first_err_valid <= (LATENCY == 0) && mismatch;
                        err_count       <= ((LATENCY == 0) && mismatch) ? CNT_W'(1) : '0;
                        idx             <= (LATENCY == 0) ? CNT_W'(1) : '0;
                        fill_cnt        <= FILL_LOAD;
                        if (LATENCY == 0 && NUM_CHECKS == 1)
                            state <= DONE;
                        else if (LATENCY <= 1)
                            state <= CHECK;
                        else
                            state <= FILL;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt - 1'b1;
                    if (fill_cnt == FILL_W'(1))
                        state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= idx;
                        end
                    end
                    if (idx == LAST_IDX)
                        state <= DONE;
                    else
                        idx <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == FILL) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed and randomized checks of result_scoreboard across three latency/width configurations.
module tb_result_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic start_v [3];
    logic stim_v  [3];
    logic obs_v   [3];
    logic busy_v  [3];
    logic done_v  [3];
    logic pass_v  [3];
    logic fev_v   [3];
    logic [7:0] err_v [3];
    logic [7:0] fei_v [3];
    logic [1:0] err_s, fei_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0: LATENCY=1 N=8, 1: LATENCY=0 N=4, 2: LATENCY=3 N=3 CNT_W=2
    result_scoreboard #(.LATENCY(1), .NUM_CHECKS(8), .CNT_W(8)) u_l1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .stim(stim_v[0]), .obs(obs_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .first_err_valid(fev_v[0]), .first_err_idx(fei_v[0]));

    result_scoreboard #(.LATENCY(0), .NUM_CHECKS(4), .CNT_W(8)) u_l0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .stim(stim_v[1]), .obs(obs_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .first_err_valid(fev_v[1]), .first_err_idx(fei_v[1]));

    result_scoreboard #(.LATENCY(3), .NUM_CHECKS(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_v[2]), .stim(stim_v[2]), .obs(obs_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_s),
        .first_err_valid(fev_v[2]), .first_err_idx(fei_s));

    assign err_v[2] = {6'd0, err_s};
    assign fei_v[2] = {6'd0, fei_s};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        for (int j = 0; j < 3; j++) begin
            start_v[j] = 1'b0;
            stim_v[j]  = 1'($urandom);
            obs_v[j]   = 1'($urandom);
        end
    endtask

    // One complete run on instance w. Sample i is stim s[i]; the result
    // for sample i is presented as o[i], lat edges after its stim.
    task automatic run(input int w, input int lat, input int n, input int maxc,
                       input logic [15:0] s, input logic [15:0] o,
                       input int pulse_at, input bit hold, input string nm);
        int exp_err;
        int exp_first;
        bit exp_fev;
        exp_err = 0;
        exp_first = 0;
        exp_fev = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (s[i] != o[i]) begin
                if (!exp_fev) exp_first = i;
                exp_fev = 1'b1;
                exp_err++;
            end
        end
        if (exp_err > maxc) exp_err = maxc;

        for (int e = 0; e < lat + n; e++) begin
            drive_idle();
            start_v[w] = (e == 0) || hold || (e == pulse_at);
            if (e < n) stim_v[w] = s[e];
            if (e >= lat && e - lat < n) obs_v[w] = o[e - lat];
            @(posedge clk);
            @(negedge clk);
            if (e < lat + n - 1) begin
                chk({nm, "_busy"}, 32'(busy_v[w]), 32'd1);
                chk({nm, "_done_early"}, 32'(done_v[w]), 32'd0);
            end
        end
        chk({nm, "_busy_end"}, 32'(busy_v[w]), 32'd0);
        chk({nm, "_done"}, 32'(done_v[w]), 32'd1);
        chk({nm, "_pass"}, 32'(pass_v[w]), 32'(exp_err == 0));
        chk({nm, "_err_count"}, 32'(err_v[w]), 32'(exp_err));
        chk({nm, "_first_valid"}, 32'(fev_v[w]), 32'(exp_fev));
        chk({nm, "_first_idx"}, 32'(fei_v[w]), 32'(exp_first));
        start_v[w] = 1'b0;
    endtask

    task automatic chk_quiet(input int w, input string nm);
        chk({nm, "_busy"}, 32'(busy_v[w]), 32'd0);
        chk({nm, "_done"}, 32'(done_v[w]), 32'd0);
        chk({nm, "_pass"}, 32'(pass_v[w]), 32'd0);
        chk({nm, "_err"}, 32'(err_v[w]), 32'd0);
        chk({nm, "_fev"}, 32'(fev_v[w]), 32'd0);
        chk({nm, "_fei"}, 32'(fei_v[w]), 32'd0);
    endtask

    initial begin
        logic [15:0] s, o;
        drive_idle();

        #1 rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) chk_quiet(j, $sformatf("reset%0d", j));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_idle();
            @(negedge clk);
        end
        chk_quiet(0, "idle_l1");

        // Matched stream, samples 1,0,1,1,0,0,1,0 (sample 0 in bit 0).
        s = 16'b0100_1101;
        run(0, 1, 8, 255, s, s, -1, 1'b0, "match");
        // Single error on sample 5, started straight from DONE.
        o = s;
        o[5] = ~o[5];
        run(0, 1, 8, 255, s, o, -1, 1'b0, "single");

        // Zero latency: obs forced low on samples 0 and 2 (stim=1 there).
        s = 16'b1101;
        o = 16'b1000;
        run(1, 0, 4, 255, s, o, -1, 1'b0, "lat0");

        // Saturation of a 2-bit counter, every sample wrong.
        s = 16'($urandom);
        run(2, 3, 3, 3, s, ~s, -1, 1'b0, "sat");

        // start during CHECK at sample 3 is ignored; then start held high throughout.
        s = 16'($urandom);
        o = s ^ 16'b0100_0100;
        run(0, 1, 8, 255, s, o, 4, 1'b0, "ign_pulse");
        s = 16'($urandom);
        run(0, 1, 8, 255, s, s, -1, 1'b1, "held0");
        s = 16'($urandom);
        o = s ^ 16'b1000_0000;
        run(0, 1, 8, 255, s, o, -1, 1'b1, "held1");

        for (int r = 0; r < 6; r++) begin
            s = 16'($urandom);
            o = s ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            run(0, 1, 8, 255, s, o, -1, 1'b0, $sformatf("rnd_l1_%0d", r));
            s = 16'($urandom);
            o = s ^ (16'($urandom) & 16'($urandom));
            run(1, 0, 4, 255, s, o, -1, 1'b0, $sformatf("rnd_l0_%0d", r));
            s = 16'($urandom);
            o = s ^ (16'($urandom) & 16'($urandom));
            run(2, 3, 3, 3, s, o, -1, 1'b0, $sformatf("rnd_sat_%0d", r));
        end

        // Mid-run reset: every sample mismatches, so err_count is nonzero before rst.
        s = 16'($urandom);
        o = ~s;
        for (int e = 0; e < 5; e++) begin
            drive_idle();
            start_v[0] = (e == 0);
            stim_v[0] = s[e];
            if (e >= 1) obs_v[0] = o[e - 1];
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrst_err_before", 32'(err_v[0]), 32'd4);
        chk("midrst_busy_before", 32'(busy_v[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        chk("midrst_err", 32'(err_v[0]), 32'd0);
        chk("midrst_fev", 32'(fev_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            @(negedge clk);
            chk($sformatf("postrst_busy%0d", c), 32'(busy_v[0]), 32'd0);
            chk($sformatf("postrst_done%0d", c), 32'(done_v[0]), 32'd0);
        end

        // Fresh run from IDLE after the reset.
        s = 16'($urandom);
        o = s ^ 16'b0000_0001;
        run(0, 1, 8, 255, s, o, -1, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
